// File: rtl/uart_rx_os_pkg.sv
// Shared UART codes and the receiver's one-hot state encoding.
// The parity and stop-bit codes are the same ones the transmitter uses.
package uart_rx_os_pkg;

    localparam logic [1:0] PARITY_NONE   = 2'd1;
    localparam logic [1:0] PARITY_ODD    = 2'd2;
    localparam logic [1:0] PARITY_EVEN   = 2'd3;

    localparam logic [1:0] STOP_BITS_ONE = 2'd1;
    localparam logic [1:0] STOP_BITS_TWO = 2'd2;

    // One-hot receiver states; ST_SPARE is never entered and decodes to IDLE.
    typedef enum logic [7:0] {
        ST_IDLE       = 8'b0000_0001,
        ST_START      = 8'b0000_0010,
        ST_DATA       = 8'b0000_0100,
        ST_PARITY     = 8'b0000_1000,
        ST_STOP       = 8'b0001_0000,
        ST_DONE       = 8'b0010_0000,
        ST_BREAK_WAIT = 8'b0100_0000,
        ST_SPARE      = 8'b1000_0000
    } uart_rx_os_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: counts 0..i_div and pulses o_tick at i_div.
// Shared between the UART receiver and transmitter.
module uart_os_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] cnt_reg;

    assign o_tick = !i_clear && (cnt_reg == i_div);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (i_clear || (cnt_reg == i_div)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with runtime framing, majority voting,
// break detection and a valid/ready output that reports overruns.
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int OVERSAMPLE     = 16,
    parameter int DIV_WIDTH      = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_rx,
    input  logic [DIV_WIDTH-1:0]                  i_div,
    input  logic [$clog2(MAX_DATA_WIDTH+1)-1:0]   i_data_bits,
    input  logic [1:0]                            i_parity,
    input  logic [1:0]                            i_stop_bits,
    output logic [MAX_DATA_WIDTH-1:0]             o_data,
    input  logic                                  i_ready,
    output logic                                  o_valid,
    output logic                                  o_frame_err,
    output logic                                  o_parity_err,
    output logic                                  o_break,
    output logic                                  o_overrun
);

    localparam int DBW = $clog2(MAX_DATA_WIDTH + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] IDX_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] IDX_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] IDX_EVAL = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] IDX_LAST = SW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0]    sync_reg;
    logic                      rx;
    uart_rx_os_state_t         state_reg;
    logic [DIV_WIDTH-1:0]      div_reg;
    logic [DBW-1:0]            data_bits_reg;
    logic [1:0]                parity_reg;
    logic                      stop_two_reg;
    logic [SW-1:0]             samp_cnt_reg;
    logic                      samp_a_reg;
    logic                      samp_b_reg;
    logic [DBW-1:0]            bit_cnt_reg;
    logic                      stop_cnt_reg;
    logic [MAX_DATA_WIDTH-1:0] shift_reg;
    logic                      par_bit_reg;
    logic                      par_bad_reg;

    logic                      active;
    logic                      tick;
    logic                      eval;
    logic                      bit_val;
    logic                      parity_en;
    logic                      par_calc;
    logic [MAX_DATA_WIDTH-1:0] bit_sel;

    // Input synchronizer; stages reset to the idle-high line level.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                sync_reg[gi] <= 1'b1;
            end else if (gi == 0) begin
                sync_reg[gi] <= i_rx;
            end else begin
                sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign rx = sync_reg[SYNC_STAGES-1];

    for (genvar gi = 0; gi < MAX_DATA_WIDTH; gi++) begin : g_bit_sel
        assign bit_sel[gi] = (bit_cnt_reg == DBW'(gi));
    end

    assign active    = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                       (state_reg == ST_PARITY) || (state_reg == ST_STOP);
    assign eval      = tick && (samp_cnt_reg == IDX_EVAL);
    assign bit_val   = maj3(samp_a_reg, samp_b_reg, rx);
    assign parity_en = (parity_reg == PARITY_ODD) || (parity_reg == PARITY_EVEN);
    assign par_calc  = (parity_reg == PARITY_ODD) ? ~^shift_reg : ^shift_reg;

    uart_os_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clear(!active),
        .i_div  (div_reg),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            div_reg       <= '0;
            data_bits_reg <= '0;
            parity_reg    <= '0;
            stop_two_reg  <= 1'b0;
            samp_cnt_reg  <= '0;
            samp_a_reg    <= 1'b0;
            samp_b_reg    <= 1'b0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            shift_reg     <= '0;
            par_bit_reg   <= 1'b0;
            par_bad_reg   <= 1'b0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_err   <= 1'b0;
            o_parity_err  <= 1'b0;
            o_break       <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (!active) begin
                samp_cnt_reg <= '0;
            end else if (tick) begin
                samp_cnt_reg <= (samp_cnt_reg == IDX_LAST) ? '0 : samp_cnt_reg + SW'(1);
            end
            if (tick && (samp_cnt_reg == IDX_A)) begin
                samp_a_reg <= rx;
            end
            if (tick && (samp_cnt_reg == IDX_B)) begin
                samp_b_reg <= rx;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!rx) begin
                        div_reg       <= i_div;
                        data_bits_reg <= i_data_bits;
                        parity_reg    <= i_parity;
                        stop_two_reg  <= (i_stop_bits == STOP_BITS_TWO);
                        shift_reg     <= '0;
                        bit_cnt_reg   <= '0;
                        stop_cnt_reg  <= 1'b0;
                        par_bit_reg   <= 1'b0;
                        par_bad_reg   <= 1'b0;
                        state_reg     <= ST_START;
                    end
                end
                ST_START: begin
                    if (eval) begin
                        state_reg <= bit_val ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (eval) begin
                        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
                            if (bit_sel[i]) begin
                                shift_reg[i] <= bit_val;
                            end
                        end
                        if (bit_cnt_reg == data_bits_reg - DBW'(1)) begin
                            state_reg <= parity_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + DBW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (eval) begin
                        par_bit_reg <= bit_val;
                        par_bad_reg <= (bit_val != par_calc);
                        state_reg   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (eval) begin
                        // A low stop bit on an all-zero frame is a line break.
                        if (!bit_val) begin
                            if ((shift_reg == '0) && !par_bit_reg) begin
                                o_break <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                            state_reg <= ST_BREAK_WAIT;
                        end else if (stop_cnt_reg == stop_two_reg) begin
                            state_reg <= ST_DONE;
                        end else begin
                            stop_cnt_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (par_bad_reg) begin
                        o_parity_err <= 1'b1;
                    end else if (o_valid && !i_ready) begin
                        o_overrun <= 1'b1;
                    end else begin
                        o_data  <= shift_reg;
                        o_valid <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                end
                ST_BREAK_WAIT: begin
                    if (rx) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: a table of framed words plus hand-written
// glitch, break, overrun, back-to-back and mid-frame reset sequences.
module tb_uart_rx_os;
    import uart_rx_os_pkg::*;

    localparam int BIT = 64;   // (i_div+1) * OVERSAMPLE with i_div = 3

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] div;
    logic [3:0]  data_bits;
    logic [1:0]  parity;
    logic [1:0]  stop_bits;
    logic [7:0]  data;
    logic        ready;
    logic        valid, frame_err, parity_err, brk, overrun;

    uart_rx_os dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .i_div       (div),
        .i_data_bits (data_bits),
        .i_parity    (parity),
        .i_stop_bits (stop_bits),
        .o_data      (data),
        .i_ready     (ready),
        .o_valid     (valid),
        .o_frame_err (frame_err),
        .o_parity_err(parity_err),
        .o_break     (brk),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int   n_vrise = 0, n_vhi = 0, n_perr = 0, n_ferr = 0, n_brk = 0, n_ovr = 0;
    int   last_rise_cyc = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            n_vrise++;
            last_rise_cyc = cyc;
        end
        if (valid)      n_vhi++;
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (brk)        n_brk++;
        if (overrun)    n_ovr++;
        prev_valid = valid;
    end

    int n_cmp = 0, n_bad = 0;
    int b_vrise, b_vhi, b_perr, b_ferr, b_brk, b_ovr;
    int t_start;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic snap();
        b_vrise = n_vrise; b_vhi = n_vhi; b_perr = n_perr;
        b_ferr = n_ferr;   b_brk = n_brk; b_ovr = n_ovr;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] par,
                              input logic two_stop, input logic flip_par,
                              input logic bad_stop, input logic scramble);
        int ones;
        logic p;
        logic [15:0] s_div;
        logic [3:0]  s_bits;
        logic [1:0]  s_par, s_stop;
        ones = 0;
        @(negedge clk);
        t_start = cyc;
        drive_bit(1'b0);
        if (scramble) begin
            s_div = div; s_bits = data_bits; s_par = parity; s_stop = stop_bits;
            div = 16'd0; data_bits = 4'd8; parity = PARITY_NONE; stop_bits = STOP_BITS_TWO;
        end
        for (int i = 0; i < nbits; i++) begin
            ones += int'(d[i]);
            drive_bit(d[i]);
        end
        if (par != PARITY_NONE) begin
            p = (par == PARITY_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            drive_bit(p ^ flip_par);
        end
        drive_bit(!bad_stop);
        if (two_stop) drive_bit(1'b1);
        rx = 1'b1;
        if (scramble) begin
            div = s_div; data_bits = s_bits; parity = s_par; stop_bits = s_stop;
        end
    endtask

    task automatic set_cfg(input int nbits, input logic [1:0] par, input logic two_stop);
        data_bits = 4'(nbits);
        parity    = par;
        stop_bits = two_stop ? STOP_BITS_TWO : STOP_BITS_ONE;
    endtask

    typedef struct {
        logic [7:0] d;
        int         nbits;
        logic [1:0] par;
        logic       two_stop;
        logic       flip_par;
        logic       bad_stop;
        logic       scramble;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_perr;
        int         exp_ferr;
        int         exp_brk;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'hA5, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 0, 0, 0};
        vecs[1] = '{8'h37, 7, PARITY_EVEN, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1, 0, 0};
        vecs[2] = '{8'h12, 7, PARITY_EVEN, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h12, 0, 0, 0};
        vecs[3] = '{8'h1A, 5, PARITY_ODD,  1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h1A, 0, 0, 0};
        vecs[4] = '{8'h81, 8, PARITY_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0, 1, 0};
        vecs[5] = '{8'h00, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 0, 0, 0};
        vecs[6] = '{8'h2C, 6, PARITY_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h2C, 0, 0, 0};
        vecs[7] = '{8'hFF, 8, PARITY_ODD,  1'b1, 1'b0, 1'b0, 1'b0, 1, 8'hFF, 0, 0, 0};
        vecs[8] = '{8'h00, 8, PARITY_EVEN, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1};
        vecs[9] = '{8'h00, 8, PARITY_ODD,  1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 0, 1, 0};

        rst_n = 1'b0; rx = 1'b1; ready = 1'b1; div = 16'd3;
        set_cfg(8, PARITY_NONE, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(valid), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_pulses", int'({frame_err, parity_err, brk, overrun}), 0);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            set_cfg(vecs[i].nbits, vecs[i].par, vecs[i].two_stop);
            snap();
            send_frame(vecs[i].d, vecs[i].nbits, vecs[i].par, vecs[i].two_stop,
                       vecs[i].flip_par, vecs[i].bad_stop, vecs[i].scramble);
            repeat (2 * BIT) @(negedge clk);
            $display("frame %0d: sent %02h bits=%0d par=%0d -> data=%02h valid_cycles=%0d perr=%0d ferr=%0d brk=%0d",
                     i, vecs[i].d, vecs[i].nbits, vecs[i].par, data, n_vhi - b_vhi,
                     n_perr - b_perr, n_ferr - b_ferr, n_brk - b_brk);
            chk($sformatf("v%0d_valid_cycles", i), n_vhi - b_vhi, vecs[i].exp_valid);
            if (vecs[i].exp_valid != 0)
                chk($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_data));
            chk($sformatf("v%0d_parity_err", i), n_perr - b_perr, vecs[i].exp_perr);
            chk($sformatf("v%0d_frame_err", i), n_ferr - b_ferr, vecs[i].exp_ferr);
            chk($sformatf("v%0d_break", i), n_brk - b_brk, vecs[i].exp_brk);
            chk($sformatf("v%0d_overrun", i), n_ovr - b_ovr, 0);
            if (i == 0)
                chk("v0_valid_latency", last_rise_cyc - t_start, 620);
        end

        // Start glitch of 16 clocks, then a good 8N1 frame.
        set_cfg(8, PARITY_NONE, 1'b0);
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        $display("glitch: valid_rises=%0d ferr=%0d brk=%0d", n_vrise - b_vrise, n_ferr - b_ferr, n_brk - b_brk);
        chk("glitch_events", (n_vrise - b_vrise) + (n_ferr - b_ferr) + (n_brk - b_brk) + (n_perr - b_perr), 0);
        snap();
        send_frame(8'h55, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        $display("after glitch: data=%02h valid_rises=%0d", data, n_vrise - b_vrise);
        chk("glitch_next_valid", n_vrise - b_vrise, 1);
        chk("glitch_next_data", int'(data), 8'h55);

        // Break: line low for 20 bit times.
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        $display("break: brk=%0d ferr=%0d valid_rises=%0d", n_brk - b_brk, n_ferr - b_ferr, n_vrise - b_vrise);
        chk("break_pulse", n_brk - b_brk, 1);
        chk("break_no_ferr", n_ferr - b_ferr, 0);
        chk("break_no_valid", n_vrise - b_vrise, 0);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("break_release_quiet", n_vrise - b_vrise, 0);
        snap();
        send_frame(8'h3C, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        $display("after break: data=%02h valid_rises=%0d", data, n_vrise - b_vrise);
        chk("break_next_data", int'(data), 8'h3C);
        chk("break_next_valid", n_vrise - b_vrise, 1);

        // Back-to-back frames with no idle gap.
        snap();
        send_frame(8'h01, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h80, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        $display("back-to-back: data=%02h valid_rises=%0d", data, n_vrise - b_vrise);
        chk("b2b_valid_rises", n_vrise - b_vrise, 2);
        chk("b2b_data", int'(data), 8'h80);

        // Overrun: consumer stalled across two frames.
        @(negedge clk);
        ready = 1'b0;
        snap();
        send_frame(8'h11, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        chk("ovr_first_data", int'(data), 8'h11);
        chk("ovr_first_valid", int'(valid), 1);
        send_frame(8'h22, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        $display("overrun: data=%02h valid=%0d overruns=%0d", data, valid, n_ovr - b_ovr);
        chk("ovr_pulse", n_ovr - b_ovr, 1);
        chk("ovr_data_kept", int'(data), 8'h11);
        chk("ovr_valid_held", int'(valid), 1);
        chk("ovr_valid_rises", n_vrise - b_vrise, 1);
        ready = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", int'(valid), 0);

        // Reset during DATA while a word is held.
        ready = 1'b0;
        send_frame(8'h5A, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        chk("rst_pre_valid", int'(valid), 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        $display("mid-frame reset: valid=%0d data=%02h", valid, data);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        snap();
        send_frame(8'hC3, 8, PARITY_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        $display("after reset: data=%02h valid_rises=%0d", data, n_vrise - b_vrise);
        chk("rst_next_data", int'(data), 8'hC3);
        chk("rst_next_valid", n_vrise - b_vrise, 1);
        chk("rst_next_errors", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_brk - b_brk), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
